t03_sram_ctrl: RTL and testbench

Single-clock access controller for the team's 1024×32 dual-port FPGA SRAM, which has one write port and one read port. It gives one writer exclusive use of the write port. It shares the read port between two read requesters under round-robin arbitration and returns tagged read responses at fixed latency. It sits between the fabric configuration streamer / debug bus and the SRAM macro; the SRAM's clk0 and clk1 are both tied to this block's clk.

---
 rtl/t03_sram_pkg.sv | 7 +
 rtl/t03_rr_arb2.sv | 15 +
 rtl/t03_sram_ctrl.sv | 78 +++++++
 tb/tb_t03_sram_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/t03_sram_pkg.sv
// t03_sram_pkg: shared constants and types for the SRAM access controller.
package t03_sram_pkg;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    typedef enum logic [1:0] {INIT, CLEAR, RUN} state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/t03_rr_arb2.sv
// t03_rr_arb2: two-way round-robin arbiter with per-request mask; pointer passes to the other side after each grant.
module t03_rr_arb2 import t03_sram_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);
    req_id_t ptr;
    logic [1:0] elig;
    assign elig = en ? (req & ~mask) : 2'b00;
    always_comb gnt = ptr ? (elig[1] ? 2'b10 : {1'b0, elig[0]}) : (elig[0] ? 2'b01 : {elig[1], 1'b0});
    always_ff @(posedge clk) ptr <= rst ? 1'b0 : (|gnt ? gnt[0] : ptr);
endmodule

// File: rtl/t03_sram_ctrl.sv
// t03_sram_ctrl: exclusive write port plus round-robin shared read port for a 1024x32 dual-port SRAM.
// Optional power-up zero fill of the whole array when T03_SRAM_CLEAR_EN is defined.
module t03_sram_ctrl import t03_sram_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd0_valid,
    output logic                  rd0_ready,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    input  logic                  rd1_valid,
    output logic                  rd1_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    state_t state, state_nx;
    logic run, wr_acc, clearing, v1;
    logic [1:0] mask, gnt;
    req_id_t id1;
    assign run = state == RUN;
    assign busy = !run;
    assign wr_ready = run;
    assign wr_acc = wr_valid && run;
    always_ff @(posedge clk) state <= rst ? INIT : state_nx;
`ifdef T03_SRAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_addr;
    assign clearing = state == CLEAR;
    always_ff @(posedge clk) clr_addr <= (rst || !clearing) ? '0 : clr_addr + ADDR_WIDTH'(1);
    always_comb state_nx = (state == INIT) ? CLEAR : (clearing && &clr_addr) ? RUN : state;
    assign sram_addr0 = clearing ? clr_addr : wr_acc ? wr_addr : '0;
`else
    assign clearing = 1'b0;
    always_comb state_nx = (state == INIT) ? RUN : state;
    assign sram_addr0 = wr_acc ? wr_addr : '0;
`endif
    assign sram_csb0 = !(wr_acc || clearing);
    assign sram_din0 = wr_acc ? wr_data : '0;
    // same-address read would race the write at the SRAM, so hold it off a cycle
    assign mask = {wr_acc && rd1_addr == wr_addr, wr_acc && rd0_addr == wr_addr};
    t03_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .req  ({rd1_valid, rd0_valid}),
        .mask (mask),
        .gnt  (gnt)
    );
    assign rd0_ready = gnt[0];
    assign rd1_ready = gnt[1];
    assign sram_csb1 = ~|gnt;
    assign sram_addr1 = gnt[1] ? rd1_addr : gnt[0] ? rd0_addr : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            id1 <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_data <= '0;
        end else begin
            v1 <= |gnt;
            id1 <= gnt[1];
            rsp_valid <= v1;
            rsp_id <= id1;
            if (v1) rsp_data <= sram_dout1;
        end
    end
endmodule

// File: tb/tb_t03_sram_ctrl.sv
// tb_t03_sram_ctrl: random and directed stimulus against a behavioural SRAM-access model; handles T03_SRAM_CLEAR_EN builds.
module tb_t03_sram_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef T03_SRAM_CLEAR_EN
    localparam int BUSY_CYC = 1025;
    localparam bit CLR = 1'b1;
`else
    localparam int BUSY_CYC = 1;
    localparam bit CLR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_valid = 1'b0, wr_ready, rd0_valid = 1'b1, rd0_ready, rd1_valid = 1'b0, rd1_ready;
    logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0, sram_addr0, sram_addr1;
    logic [DW-1:0] wr_data = '0, rsp_data, sram_din0, sram_dout1 = '0;
    logic rsp_valid, rsp_id, busy, sram_csb0, sram_csb1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    t03_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
        .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    function automatic logic [DW-1:0] pre(input int i);
        return 32'hA500_0000 ^ DW'(i * 32'h9E37);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM macro: inputs registered on posedge, array resolved on the following negedge (read sees old data)
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ref_mem [1024];
    logic w_en = 1'b0, r_en = 1'b0;
    logic [AW-1:0] w_a, r_a;
    logic [DW-1:0] w_d;
    initial for (int i = 0; i < 1024; i++) begin
        mem[i] = pre(i);
        ref_mem[i] = pre(i);
    end
    always @(posedge clk) begin
        w_en <= !sram_csb0; w_a <= sram_addr0; w_d <= sram_din0;
        r_en <= !sram_csb1; r_a <= sram_addr1;
    end
    always @(negedge clk) begin
        if (r_en) sram_dout1 <= mem[r_a];
        if (w_en) mem[w_a] <= w_d;
    end

    // Reference model: cycle count since reset, a fairness pointer, a memory image and a queue of due responses
    typedef struct { longint due; bit id; logic [DW-1:0] data; } rsp_t;
    rsp_t q[$];
    longint cyc = 0;
    int rc = 0;
    bit ptr = 1'b0;
    always @(negedge clk) begin
        bit run, clr, wacc;
        bit [1:0] el;
        int win;
        rsp_t r;
        if (rst) begin
            rc = 0;
            ptr = 1'b0;
            q.delete();
        end else begin
            run = rc >= BUSY_CYC;
            clr = !run && rc >= 1;
            wacc = run && wr_valid;
            el[0] = run && rd0_valid && !(wacc && rd0_addr == wr_addr);
            el[1] = run && rd1_valid && !(wacc && rd1_addr == wr_addr);
            win = el[ptr] ? int'(ptr) : el[!ptr] ? int'(!ptr) : -1;
            chk("busy", busy, !run);
            chk("wr_ready", wr_ready, run);
            chk("rd0_ready", rd0_ready, win == 0);
            chk("rd1_ready", rd1_ready, win == 1);
            chk("sram_csb0", sram_csb0, !(wacc || clr));
            chk("sram_addr0", sram_addr0, clr ? AW'(rc - 1) : wacc ? wr_addr : '0);
            chk("sram_din0", sram_din0, wacc ? wr_data : '0);
            chk("sram_csb1", sram_csb1, win < 0);
            chk("sram_addr1", sram_addr1, win == 1 ? rd1_addr : win == 0 ? rd0_addr : '0);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_data", rsp_data, q[0].data);
                void'(q.pop_front());
            end else chk("rsp_valid", rsp_valid, 0);
            if (win >= 0) begin
                r.due = cyc + 2;
                r.id = (win == 1);
                r.data = ref_mem[win == 1 ? rd1_addr : rd0_addr];
                q.push_back(r);
                ptr = (win == 0);
            end
            if (wacc) ref_mem[wr_addr] = wr_data;
            if (clr) ref_mem[AW'(rc - 1)] = '0;
            rc++;
        end
        cyc++;
    end

    task automatic step(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1);
        @(posedge clk);
        #1;
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd0_valid = v0; rd0_addr = a0; rd1_valid = v1; rd1_addr = a1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_run(input string name);
        int nb = 0;
        while (busy && nb < 3000) begin
            nb++;
            step(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0, '0);
        end
        chk(name, nb, BUSY_CYC);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", busy, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_csb0", sram_csb0, 1);
        chk("reset_csb1", sram_csb1, 1);
        chk("reset_addr0", sram_addr0, 0);
        chk("reset_addr1", sram_addr1, 0);
        chk("reset_din0", sram_din0, 0);
        chk("reset_rd0_ready", rd0_ready, 0);
        chk("reset_wr_ready", wr_ready, 0);
        step(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0, '0);
        chk("init_busy", busy, 1);
        chk("init_rd0_ready", rd0_ready, 0);
        wait_run("busy_len");
        chk("run_rd0_ready", rd0_ready, 1);
        idle(3);
        // write then read-after-write through requester 1
        step(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 10'h005);
        chk("raw_rd1_ready", rd1_ready, 1);
        idle(2);
        chk("raw_rsp_valid", rsp_valid, 1);
        chk("raw_rsp_id", rsp_id, 1);
        chk("raw_rsp_data", rsp_data, 32'hDEADBEEF);
        idle(1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, 10'h010, 1'b1, 10'h020);
            chk("alt_rd0", rd0_ready, i % 2 == 0);
            chk("alt_rd1", rd1_ready, i % 2 == 1);
        end
        idle(3);
        // same-address hazard, then a parallel different-address pair
        step(1'b0, 1'b1, 10'h0AA, 32'h12345678, 1'b1, 10'h0AA, 1'b0, '0);
        chk("haz_blocked", rd0_ready, 0);
        chk("haz_write", sram_csb0, 0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 10'h0AA, 1'b0, '0);
        chk("haz_retry", rd0_ready, 1);
        idle(2);
        chk("haz_rsp_valid", rsp_valid, 1);
        chk("haz_rsp_id", rsp_id, 0);
        chk("haz_rsp_data", rsp_data, 32'h12345678);
        step(1'b0, 1'b1, 10'h0BB, 32'h0BADF00D, 1'b1, 10'h0CC, 1'b0, '0);
        chk("par_rd0_ready", rd0_ready, 1);
        chk("par_csb1", sram_csb1, 0);
        idle(3);
        // reset one cycle after a grant drops the read
        step(1'b0, 1'b0, '0, '0, 1'b1, 10'h030, 1'b0, '0);
        chk("mid_grant", rd0_ready, 1);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_busy", busy, 1);
        chk("mid_csb0", sram_csb0, 1);
        chk("mid_csb1", sram_csb1, 1);
        chk("mid_wr_ready", wr_ready, 0);
        wait_run("busy_len_2");
        step(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0, '0);
        chk("top_grant", rd0_ready, 1);
        idle(2);
        chk("top_rsp_valid", rsp_valid, 1);
        chk("top_rsp_data", rsp_data, CLR ? 32'h0 : pre(1023));
        for (int i = 0; i < 1500; i++) begin
            bit far;
            far = $urandom_range(0, 9) == 0;
            step(1'b0, 1'($urandom_range(0, 1)), far ? AW'($urandom) : AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)));
        end
        idle(4);
        chk("drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
